// File: rtl/dmem_responder.sv
// Data-memory responder: 4096x32 RAM, a 4-deep transmit FIFO at TXDATA and a CTRL register.
// Build option DMEM_WRITE_FIRST_EN makes RAM loads write-first; the default is read-first.
module dmem_responder (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        io_valid,
    output logic [31:0] io_data,
    input  logic        io_ready,
    output logic        io_overflow
);

    localparam logic [31:0] TXDATA_ADDR = 32'h0000_F000;
    localparam logic [31:0] CTRL_ADDR   = 32'h0000_F001;

    logic [31:0] mem [4096];
    logic [31:0] fifo_mem [4];
    logic [1:0]  wptr, rptr;
    logic [2:0]  count, count_nxt;
    logic        ram_hit, tx_hit, ctrl_hit;
    logic        push_req, push, pop, ovf_evt, ovf_clr;
    logic [31:0] rd_data;

    assign ram_hit  = (address_dmem[31:12] == 20'h0);
    assign tx_hit   = (address_dmem == TXDATA_ADDR);
    assign ctrl_hit = (address_dmem == CTRL_ADDR);

    assign io_valid = (count != 3'd0);
    assign io_data  = fifo_mem[rptr];

    // When full, a store only fits if the head leaves on the same edge.
    assign pop      = io_valid && io_ready;
    assign push_req = wren && tx_hit;
    assign push     = push_req && ((count != 3'd4) || pop);
    assign ovf_evt  = push_req && !push;
    assign ovf_clr  = wren && ctrl_hit && data[0];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 3'd1;
            2'b01:   count_nxt = count - 3'd1;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        rd_data = 32'h0;
        if (ram_hit) begin
`ifdef DMEM_WRITE_FIRST_EN
            rd_data = wren ? data : mem[address_dmem[11:0]];
`else
            rd_data = mem[address_dmem[11:0]];
`endif
        end else if (tx_hit) begin
            rd_data = {io_overflow, 28'h0, count};
        end
    end

    // Storage arrays carry no reset.
    always_ff @(posedge clock) begin
        if (wren && ram_hit)
            mem[address_dmem[11:0]] <= data;
        if (push)
            fifo_mem[wptr] <= data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_dmem      <= 32'h0;
            count       <= 3'd0;
            wptr        <= 2'd0;
            rptr        <= 2'd0;
            io_overflow <= 1'b0;
        end else begin
            q_dmem <= rd_data;
            count  <= count_nxt;
            if (push)
                wptr <= wptr + 2'd1;
            if (pop)
                rptr <= rptr + 2'd1;
            // A drop on the clearing edge keeps the flag set.
            if (ovf_evt)
                io_overflow <= 1'b1;
            else if (ovf_clr)
                io_overflow <= 1'b0;
        end
    end

endmodule
